// File: rtl/dac_serial_multi_tx.sv
// ----------------------------------------------------------------------------
// dac_serial_multi_tx
//   N-channel serial DAC frame transmitter. One sample per channel is taken
//   over a valid/ready handshake, formatted into a FRAME-bit word per channel
//   ({zeros, pd_mode, sample'}), and all words are shifted out MSB-first in
//   lock-step on a shared SCLK / NSYNC pair, one SDATA line per channel.
//   Optional auto-refresh re-sends the last accepted set while idle.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   din_valid/din_ready  sample-set handshake (ready only in IDLE)
//   din            NCH*DW samples, channel k at din[k*DW +: DW]
//   pd_mode        DAC power-down bits, latched together with din
//   auto_refresh   re-send held set when idle and no new set offered
//   busy           frame in progress
//   frame_done     one-cycle pulse when the frame's last bit is out
//   SCLK           serial clock, idles high, DAC samples on falling edge
//   NSYNC          active-low frame sync
//   SDATA          serial data, channel k on SDATA[k]
// ----------------------------------------------------------------------------

// Per-channel datapath: formats the word, keeps the held copy for refresh and
// owns the shift register whose MSB drives the channel's SDATA.
module dac_tx_lane #(
  parameter int DW        = 12,
  parameter int FRAME     = 16,
  parameter int SIGNED_IN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample,
  input  logic [1:0]    pd,
  input  logic          capture,  // new set accepted: update held copy and load
  input  logic          reload,   // auto-refresh: load from held copy
  input  logic          shift,    // advance one bit (on SCLK rising edge)
  output logic          sdata
);

  // Two's complement -> offset binary is just an MSB inversion.
  localparam logic [DW-1:0] FLIP = (SIGNED_IN != 0) ? {1'b1, {(DW-1){1'b0}}}
                                                    : {DW{1'b0}};

  logic [FRAME-1:0] word;
  logic [FRAME-1:0] held;
  logic [FRAME-1:0] sreg;

  // Upper bits stay zero; written bitwise so FRAME == DW+2 needs no
  // zero-width replication.
  always_comb begin
    word              = '0;
    word[DW+1:DW]     = pd;
    word[DW-1:0]      = sample ^ FLIP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
      sreg <= '0;
    end else if (capture) begin
      held <= word;
      sreg <= word;
    end else if (reload) begin
      sreg <= held;
    end else if (shift) begin
      // Zero fill: after FRAME shifts the register is empty, so SDATA is
      // already 0 when the frame ends without any extra clearing.
      sreg <= {sreg[FRAME-2:0], 1'b0};
    end
  end

  assign sdata = sreg[FRAME-1];

endmodule

module dac_serial_multi_tx #(
  parameter int NCH       = 2,
  parameter int DW        = 12,
  parameter int FRAME     = 16,
  parameter int CLKDIV    = 2,
  parameter int GAP_CYC   = 4,
  parameter int SIGNED_IN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [NCH*DW-1:0] din,
  input  logic [1:0]        pd_mode,
  input  logic              auto_refresh,
  output logic              busy,
  output logic              frame_done,
  output logic              SCLK,
  output logic              NSYNC,
  output logic [NCH-1:0]    SDATA
);

  localparam int DIV_W = (CLKDIV  > 1) ? $clog2(CLKDIV)  : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int EDG_W = $clog2(2*FRAME);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [EDG_W-1:0] EDG_LAST = EDG_W'(2*FRAME - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [EDG_W-1:0] edg_cnt, edg_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             has_data, has_nx;
  logic             sclk_nx, nsync_nx, done_nx;
  logic             capture, reload, shift;

  // --------------------------------------------------------------------------
  // Next-state / next-output logic. Every output is computed here one cycle
  // early and registered below, so SCLK/NSYNC/SDATA never see a
  // combinational path from the inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    edg_nx   = edg_cnt;
    gap_nx   = gap_cnt;
    has_nx   = has_data;
    sclk_nx  = SCLK;
    nsync_nx = NSYNC;
    done_nx  = 1'b0;
    capture  = 1'b0;
    reload   = 1'b0;
    shift    = 1'b0;

    unique case (state)
      IDLE: begin
        sclk_nx  = 1'b1;
        nsync_nx = 1'b1;
        // New data wins over refresh.
        if (din_valid && din_ready) begin
          capture  = 1'b1;
          has_nx   = 1'b1;
          state_nx = SETUP;
          nsync_nx = 1'b0;
          div_nx   = '0;
        end else if (auto_refresh && has_data) begin
          reload   = 1'b1;
          state_nx = SETUP;
          nsync_nx = 1'b0;
          div_nx   = '0;
        end
      end

      // NSYNC low, SCLK high, MSB already on SDATA for CLKDIV cycles; the
      // exit edge is the first SCLK falling edge.
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          div_nx   = '0;
          edg_nx   = '0;
          sclk_nx  = 1'b0;
          state_nx = SHIFT;
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end

      // edg_cnt counts half-period boundaries inside SHIFT. Boundaries
      // 1..2*FRAME-1 toggle SCLK (the falling edge at boundary 0 happened on
      // entry); boundary 2*FRAME closes the frame with SCLK already high.
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nx = '0;
          if (edg_cnt == EDG_LAST) begin
            state_nx = HOLD;
            nsync_nx = 1'b1;
            done_nx  = 1'b1;
            gap_nx   = '0;
          end else begin
            edg_nx  = edg_cnt + EDG_W'(1);
            sclk_nx = ~SCLK;
            // Data moves on the rising edge so it is stable at the falling.
            shift   = ~SCLK;
          end
        end else begin
          div_nx = div_cnt + DIV_W'(1);
        end
      end

      HOLD: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
        end else begin
          gap_nx = gap_cnt + GAP_W'(1);
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      edg_cnt    <= '0;
      gap_cnt    <= '0;
      has_data   <= 1'b0;
      SCLK       <= 1'b1;
      NSYNC      <= 1'b1;
      frame_done <= 1'b0;
      din_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      div_cnt    <= div_nx;
      edg_cnt    <= edg_nx;
      gap_cnt    <= gap_nx;
      has_data   <= has_nx;
      SCLK       <= sclk_nx;
      NSYNC      <= nsync_nx;
      frame_done <= done_nx;
      din_ready  <= (state_nx == IDLE);
      busy       <= (state_nx != IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Channel lanes
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    dac_tx_lane #(
      .DW        (DW),
      .FRAME     (FRAME),
      .SIGNED_IN (SIGNED_IN)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .sample  (din[k*DW +: DW]),
      .pd      (pd_mode),
      .capture (capture),
      .reload  (reload),
      .shift   (shift),
      .sdata   (SDATA[k])
    );
  end

endmodule

// File: tb/tb_dac_serial_multi_tx.sv
// Bench for dac_serial_multi_tx: two instances share stimulus, one with
// unsigned samples (ua) and one with the default signed conversion (ub).
// A negedge monitor reconstructs each frame from the serial pins.
module tb_dac_serial_multi_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [23:0] din = '0;
  logic [1:0]  pd_mode = '0;
  logic        auto_refresh = 1'b0;

  logic       rdy_a, busy_a, done_a, sclk_a, nsync_a;
  logic [1:0] sd_a;
  logic       din_ready, busy, frame_done, SCLK, NSYNC;
  logic [1:0] SDATA;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dac_serial_multi_tx #(.SIGNED_IN(0)) ua (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy_a), .din(din),
    .pd_mode(pd_mode), .auto_refresh(auto_refresh), .busy(busy_a),
    .frame_done(done_a), .SCLK(sclk_a), .NSYNC(nsync_a), .SDATA(sd_a));

  dac_serial_multi_tx ub (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .pd_mode(pd_mode), .auto_refresh(auto_refresh), .busy(busy),
    .frame_done(frame_done), .SCLK(SCLK), .NSYNC(NSYNC), .SDATA(SDATA));

  // ---------------- frame monitor (ub timing, both instances' data) --------
  int          cyc = 0, frames = 0, done_cnt = 0;
  int          cur_low = 0, cur_falls = 0, f_low = 0, f_falls = 0;
  int          hi_run = 0, gap = 0, last_fall = 0, fall_period = 0;
  logic [15:0] ca0, ca1, cb0, cb1, fa0, fa1, fb0, fb1;
  logic        pn = 1'b1, ps = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pn = 1'b1; ps = 1'b1; cur_falls = 0; cur_low = 0; hi_run = 0;
    end else begin
      if (pn && !NSYNC) begin
        cur_falls = 0; cur_low = 0;
        ca0 = '0; ca1 = '0; cb0 = '0; cb1 = '0;
        fall_period = cyc - last_fall; last_fall = cyc;
        gap = hi_run; hi_run = 0;
      end
      if (!NSYNC) begin
        cur_low++;
        if (ps && !SCLK) begin
          cur_falls++;
          ca0 = {ca0[14:0], sd_a[0]};  ca1 = {ca1[14:0], sd_a[1]};
          cb0 = {cb0[14:0], SDATA[0]}; cb1 = {cb1[14:0], SDATA[1]};
        end
      end else begin
        hi_run++;
      end
      if (!pn && NSYNC) begin
        frames++; f_low = cur_low; f_falls = cur_falls;
        fa0 = ca0; fa1 = ca1; fb0 = cb0; fb1 = cb1;
      end
      if (frame_done) done_cnt++;
      pn = NSYNC; ps = SCLK;
    end
  end

  // ---------------- helpers (stimulus only) --------------------------------
  // Offers a set and returns just after the accepting edge.
  task automatic send(input logic [11:0] c0, input logic [11:0] c1,
                      input logic [1:0] p, output bit ok);
    din = {c1, c0}; pd_mode = p; din_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (din_ready) begin
        ok = 1'b1; @(posedge clk); #1; break;
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!din_ready && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    vectors++; if (SCLK !== 1'b1) begin miscompares++; $display("FAIL reset_sclk got %b want 1", SCLK); end
    vectors++; if (NSYNC !== 1'b1) begin miscompares++; $display("FAIL reset_nsync got %b want 1", NSYNC); end
    vectors++; if (SDATA !== 2'b00 || sd_a !== 2'b00) begin miscompares++; $display("FAIL reset_sdata got %b/%b want 00", SDATA, sd_a); end
    vectors++; if (din_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_ctl got rdy=%b busy=%b done=%b want 1 0 0", din_ready, busy, frame_done); end
    rst = 1'b0;
    cycles(3);
    vectors++; if (NSYNC !== 1'b1 || busy !== 1'b0 || din_ready !== 1'b1) begin miscompares++; $display("FAIL idle_after_reset got nsync=%b busy=%b rdy=%b want 1 0 1", NSYNC, busy, din_ready); end
  endtask

  task automatic test_unsigned_frame();
    bit ok; int lat, fr0, dn0;
    fr0 = frames; dn0 = done_cnt;
    send(12'hA5C, 12'h3F0, 2'b00, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL u_accept got no accept want accept"); end
    vectors++; if (busy !== 1'b1 || din_ready !== 1'b0 || NSYNC !== 1'b0) begin miscompares++; $display("FAIL u_start got busy=%b rdy=%b nsync=%b want 1 0 0", busy, din_ready, NSYNC); end
    wait_ready(lat);
    vectors++; if (lat !== 70) begin miscompares++; $display("FAIL u_latency got %0d want 70", lat); end
    vectors++; if (f_low !== 66) begin miscompares++; $display("FAIL u_nsync_low got %0d want 66", f_low); end
    vectors++; if (f_falls !== 16) begin miscompares++; $display("FAIL u_falls got %0d want 16", f_falls); end
    vectors++; if (fa0 !== 16'h0A5C) begin miscompares++; $display("FAIL u_ch0 got %h want 0a5c", fa0); end
    vectors++; if (fa1 !== 16'h03F0) begin miscompares++; $display("FAIL u_ch1 got %h want 03f0", fa1); end
    vectors++; if (frames - fr0 !== 1) begin miscompares++; $display("FAIL u_frames got %0d want 1", frames - fr0); end
    vectors++; if (done_cnt - dn0 !== 1) begin miscompares++; $display("FAIL u_done_pulses got %0d want 1", done_cnt - dn0); end
    vectors++; if (SDATA !== 2'b00 || NSYNC !== 1'b1 || SCLK !== 1'b1) begin miscompares++; $display("FAIL u_idle_pins got sd=%b ns=%b sc=%b want 00 1 1", SDATA, NSYNC, SCLK); end
  endtask

  task automatic test_signed_frame();
    bit ok; int lat;
    send(12'hFFF, 12'h000, 2'b11, ok);
    wait_ready(lat);
    vectors++; if (!ok || lat !== 70) begin miscompares++; $display("FAIL s_handshake got ok=%0d lat=%0d want 1 70", ok, lat); end
    vectors++; if (fb0 !== 16'h37FF) begin miscompares++; $display("FAIL s_ch0 got %h want 37ff", fb0); end
    vectors++; if (fb1 !== 16'h3800) begin miscompares++; $display("FAIL s_ch1 got %h want 3800", fb1); end
    vectors++; if (fa0 !== 16'h3FFF || fa1 !== 16'h3000) begin miscompares++; $display("FAIL s_unsigned_twin got %h %h want 3fff 3000", fa0, fa1); end
  endtask

  task automatic test_back_to_back();
    bit ok; int n, fr0, lat;
    fr0 = frames;
    send(12'h123, 12'h456, 2'b01, ok);
    // second set offered immediately and held until taken
    din = {12'h800, 12'h7FF}; pd_mode = 2'b10; din_valid = 1'b1; n = 0;
    for (int i = 0; i < 300; i++) begin
      if (din_ready) begin @(posedge clk); #1; n++; break; end
      @(posedge clk); #1; n++;
    end
    din_valid = 1'b0;
    vectors++; if (n !== 71) begin miscompares++; $display("FAIL b2b_accept_spacing got %0d want 71", n); end
    vectors++; if (fb0 !== 16'h1923 || fb1 !== 16'h1C56) begin miscompares++; $display("FAIL b2b_first got %h %h want 1923 1c56", fb0, fb1); end
    wait_ready(lat);
    vectors++; if (fb0 !== 16'h2FFF || fb1 !== 16'h2000) begin miscompares++; $display("FAIL b2b_second got %h %h want 2fff 2000", fb0, fb1); end
    vectors++; if (gap !== 5) begin miscompares++; $display("FAIL b2b_gap got %0d want 5", gap); end
    vectors++; if (frames - fr0 !== 2 || f_falls !== 16) begin miscompares++; $display("FAIL b2b_frames got %0d/%0d want 2/16", frames - fr0, f_falls); end
  endtask

  task automatic test_auto_refresh();
    bit ok; int fr0, lat;
    rst = 1'b1; cycles(2); rst = 1'b0;
    auto_refresh = 1'b1; fr0 = frames;
    cycles(100);
    vectors++; if (frames !== fr0 || busy !== 1'b0) begin miscompares++; $display("FAIL ar_no_data got frames+%0d busy=%b want +0 0", frames - fr0, busy); end
    send(12'h555, 12'hAAA, 2'b00, ok);
    for (int i = 0; i < 400 && frames < fr0 + 3; i++) begin @(posedge clk); #1; end
    vectors++; if (frames < fr0 + 3) begin miscompares++; $display("FAIL ar_repeat got %0d frames want 3", frames - fr0); end
    vectors++; if (fall_period !== 71) begin miscompares++; $display("FAIL ar_period got %0d want 71", fall_period); end
    vectors++; if (fb0 !== 16'h0D55 || fb1 !== 16'h02AA || f_falls !== 16) begin miscompares++; $display("FAIL ar_words got %h %h/%0d want 0d55 02aa/16", fb0, fb1, f_falls); end
    auto_refresh = 1'b0;
    wait_ready(lat);
    cycles(2);
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int fr0, lat;
    bit hit = 1'b0;
    auto_refresh = 1'b1;
    send(12'h100, 12'h200, 2'b00, ok);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cur_falls == 10) begin hit = 1'b1; break; end
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL mid_reach_edge10 got timeout want 10 falls"); end
    rst = 1'b1; #1;
    vectors++; if (NSYNC !== 1'b1 || SCLK !== 1'b1 || SDATA !== 2'b00) begin miscompares++; $display("FAIL mid_reset_pins got ns=%b sc=%b sd=%b want 1 1 00", NSYNC, SCLK, SDATA); end
    vectors++; if (busy !== 1'b0 || din_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ctl got busy=%b rdy=%b want 0 1", busy, din_ready); end
    cycles(2); rst = 1'b0; fr0 = frames;
    cycles(150);
    vectors++; if (frames !== fr0 || busy !== 1'b0 || NSYNC !== 1'b1) begin miscompares++; $display("FAIL mid_no_refresh got frames+%0d busy=%b ns=%b want +0 0 1", frames - fr0, busy, NSYNC); end
    auto_refresh = 1'b0;
    send(12'h7FF, 12'h001, 2'b01, ok);
    wait_ready(lat);
    vectors++; if (lat !== 70 || fb0 !== 16'h1FFF || fb1 !== 16'h1801) begin miscompares++; $display("FAIL mid_resume got lat=%0d %h %h want 70 1fff 1801", lat, fb0, fb1); end
  endtask

  initial begin
    test_reset();
    test_unsigned_frame();
    test_signed_frame();
    test_back_to_back();
    test_auto_refresh();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
